i2s_tx_serializer: RTL

Playback-side I2S transmitter sitting directly downstream of the sample sources (triangle source, mixer output). It takes stereo signed samples on an mclk-domain valid strobe and serializes them to the codec. It generates bclk (mclk/4) and pblrc (mclk/256, the sample rate) from a single frame counter. It also exports pblrc and a one-cycle frame tick, which upstream stages use as their sample-rate clock or enable.

---
 rtl/i2s_tx_serializer.sv | 98 +++++++++
 1 files changed

// File: rtl/i2s_tx_serializer.sv
// I2S playback transmitter: holds one pending stereo sample and reloads it at each frame boundary.
// It serializes the sample MSB first and generates bclk, pblrc and a frame tick from one 8-bit counter.
module i2s_tx_serializer #(
  parameter int SAMPLE_BITS = 16
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic [SAMPLE_BITS-1:0] in_l,
  input  logic [SAMPLE_BITS-1:0] in_r,
  input  logic                   in_valid,
  input  logic                   mute,
  output logic                   bclk,
  output logic                   pblrc,
  output logic                   pbdat,
  output logic                   frame_tick,
  output logic                   underrun,
  output logic                   overrun
);

  localparam logic [5:0] SB = 6'(SAMPLE_BITS);

  logic [7:0]             cnt_r;
  logic                   started_r;
  logic                   pending_r;
  logic [SAMPLE_BITS-1:0] hold_l_r;
  logic [SAMPLE_BITS-1:0] hold_r_r;
  logic [SAMPLE_BITS-1:0] frame_l_r;
  logic [SAMPLE_BITS-1:0] frame_r_r;

  logic [7:0]             cnt_next_s;
  logic                   load_s;
  logic [4:0]             slot_next_s;
  logic [5:0]             idx_s;
  logic [SAMPLE_BITS-1:0] word_s;
  logic [SAMPLE_BITS-1:0] shifted_s;
  logic                   pbdat_next_s;

  // Outputs are registered from the next counter value, so each one lines up with cnt.
  // The first cycle after reset holds cnt at 0 so that frame_tick marks that cycle.
  always_comb begin
    cnt_next_s   = started_r ? (cnt_r + 8'd1) : 8'd0;
    load_s       = started_r && (cnt_r == 8'hFF);
    slot_next_s  = cnt_next_s[6:2];
    word_s       = cnt_next_s[7] ? frame_r_r : frame_l_r;
    idx_s        = SB - {1'b0, slot_next_s};
    shifted_s    = word_s >> idx_s;
    if ((slot_next_s != 5'd0) && ({1'b0, slot_next_s} <= SB)) begin
      pbdat_next_s = shifted_s[0];
    end else begin
      pbdat_next_s = 1'b0;
    end
  end

  // Counter, sample holding and frame load, sticky flags and output flops.
  always_ff @(posedge mclk) begin
    if (rst) begin
      cnt_r      <= 8'd0;
      started_r  <= 1'b0;
      pending_r  <= 1'b0;
      hold_l_r   <= {SAMPLE_BITS{1'b0}};
      hold_r_r   <= {SAMPLE_BITS{1'b0}};
      frame_l_r  <= {SAMPLE_BITS{1'b0}};
      frame_r_r  <= {SAMPLE_BITS{1'b0}};
      underrun   <= 1'b0;
      overrun    <= 1'b0;
      bclk       <= 1'b0;
      pblrc      <= 1'b0;
      pbdat      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      cnt_r      <= cnt_next_s;
      started_r  <= 1'b1;
      bclk       <= cnt_next_s[1];
      pblrc      <= cnt_next_s[7];
      pbdat      <= pbdat_next_s;
      frame_tick <= (cnt_next_s == 8'd0);
      if (load_s) begin
        // With nothing pending, hold still carries the previous sample, which is retransmitted.
        frame_l_r <= mute ? {SAMPLE_BITS{1'b0}} : hold_l_r;
        frame_r_r <= mute ? {SAMPLE_BITS{1'b0}} : hold_r_r;
        if (!pending_r) begin
          underrun <= 1'b1;
        end
      end
      if (in_valid) begin
        hold_l_r  <= in_l;
        hold_r_r  <= in_r;
        pending_r <= 1'b1;
        if (pending_r && !load_s) begin
          overrun <= 1'b1;
        end
      end else if (load_s) begin
        pending_r <= 1'b0;
      end
    end
  end

endmodule
